if_prefetch_queue: RTL and testbench



---
 rtl/if_prefetch_queue_if.sv | 33 +++
 rtl/if_prefetch_queue.sv | 132 +++++++++++++
 tb/tb_if_prefetch_queue.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_queue_if.sv
// Bus bundle for the instruction prefetch queue.
//   imem_*            : request/acknowledge channel to instruction memory
//   PCSrcE/PCTargetE  : redirect from execute
//   StallD            : hold request from hazard logic
//   InstrD/PCD/PCPlus4D/ValidD : FIFO head presented to decode
// Modport master is the prefetch side; slave is the surrounding pipeline/memory.
interface if_prefetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  PCSrcE, PCTargetE, StallD,
        output InstrD, PCD, PCPlus4D, ValidD
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output PCSrcE, PCTargetE, StallD,
        input  InstrD, PCD, PCPlus4D, ValidD
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue. Issues sequential word fetches over a req/ack
// handshake, buffers {PC, instruction} pairs in a DEPTH-entry FIFO and
// presents the head to decode. Handles decode stall and execute redirect,
// including discarding a fetch that is in flight when the redirect arrives.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : if_prefetch_queue_if.master (memory channel, redirect, decode head)
//
// state | meaning
// RUN   | normal fetching; acked data is pushed into the FIFO
// DROP  | a redirected fetch is still outstanding; its data is discarded
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 rst,
    if_prefetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {RUN, DROP} state_t;

    state_t          state, nextState;
    logic [31:0]     fetchPc, fetchPcNext;
    logic [31:0]     pendPc, pendPcNext;
    logic [AW-1:0]   rdPtr, wrPtr;
    logic [CW-1:0]   count;
    logic [31:0]     pcMem    [DEPTH];
    logic [31:0]     instrMem [DEPTH];

    logic        imemReq;
    logic        validInt;
    logic        push, pop, flush;
    logic [31:0] target;

    assign target   = bus.PCTargetE & ~32'h3;
    assign validInt = (count != '0);
    assign imemReq  = !rst && ((state == DROP) || (count < CW'(DEPTH)));

    assign bus.imem_req  = imemReq;
    assign bus.imem_addr = fetchPc;
    assign bus.ValidD    = !rst && validInt;
    // Head fields read zero while reset is applied.
    assign bus.InstrD    = rst ? 32'h0 : instrMem[rdPtr];
    assign bus.PCD       = rst ? 32'h0 : pcMem[rdPtr];
    assign bus.PCPlus4D  = rst ? 32'h0 : pcMem[rdPtr] + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            fetchPc <= RESET_PC;
            pendPc  <= RESET_PC;
        end else begin
            state   <= nextState;
            fetchPc <= fetchPcNext;
            pendPc  <= pendPcNext;
        end
    end

    always_comb begin
        nextState   = state;
        fetchPcNext = fetchPc;
        pendPcNext  = pendPc;
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        case (state)
            RUN: begin
                if (bus.PCSrcE) begin
                    flush = 1'b1;
                    if (bus.imem_ack && imemReq) begin
                        fetchPcNext = target;
                    end else if (imemReq) begin
                        // Keep the outstanding request stable; redirect later.
                        pendPcNext = target;
                        nextState  = DROP;
                    end else begin
                        fetchPcNext = target;
                    end
                end else begin
                    pop = validInt && !bus.StallD;
                    if (bus.imem_ack && imemReq) begin
                        push        = 1'b1;
                        fetchPcNext = fetchPc + 32'd4;
                    end
                end
            end
            DROP: begin
                flush = bus.PCSrcE;
                if (bus.imem_ack) begin
                    fetchPcNext = bus.PCSrcE ? target : pendPc;
                    nextState   = RUN;
                end else if (bus.PCSrcE) begin
                    pendPcNext = target;
                end
            end
            default: nextState = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pcMem[i]    <= 32'h0;
                instrMem[i] <= 32'h0;
            end
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pcMem[wrPtr]    <= fetchPc;
                instrMem[wrPtr] <= bus.imem_rdata;
                wrPtr           <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench for if_prefetch_queue against a queue-based reference model.
module tb_if_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst;
    if_prefetch_queue_if bus ();

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      q[$];
    logic [31:0] mPc;
    logic [31:0] mPend;
    bit          mDrop;
    int          nAsserts;
    int          nFails;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs at negedge, check combinational outputs,
    // advance the model, then check the registered head after the edge.
    task automatic step(input bit r, input bit wantAck, input bit stall,
                        input bit redir, input logic [31:0] tgt, input logic [31:0] rdata);
        bit          expReq;
        bit          ack;
        logic [31:0] t;
        rst            = r;
        bus.StallD     = stall;
        bus.PCSrcE     = redir;
        bus.PCTargetE  = tgt;
        bus.imem_rdata = rdata;
        expReq = !r && (mDrop || q.size() < DEPTH);
        ack    = wantAck && expReq;
        bus.imem_ack = ack;
        #1;
        checkEq("imem_req", {31'b0, bus.imem_req}, {31'b0, expReq});
        if (expReq) checkEq("imem_addr", bus.imem_addr, mPc);
        if (r) begin
            checkEq("rst_ValidD", {31'b0, bus.ValidD}, 32'h0);
            checkEq("rst_InstrD", bus.InstrD, 32'h0);
            checkEq("rst_PCD", bus.PCD, 32'h0);
            checkEq("rst_PCPlus4D", bus.PCPlus4D, 32'h0);
        end

        t = {tgt[31:2], 2'b00};
        if (r) begin
            q.delete();
            mPc   = RESET_PC;
            mDrop = 0;
        end else if (redir) begin
            q.delete();
            if (ack) begin
                mPc   = t;
                mDrop = 0;
            end else if (expReq) begin
                mPend = t;
                mDrop = 1;
            end else begin
                mPc = t;
            end
        end else if (mDrop) begin
            if (ack) begin
                mPc   = mPend;
                mDrop = 0;
            end
        end else begin
            if (q.size() != 0 && !stall) void'(q.pop_front());
            if (ack) begin
                q.push_back('{pc: mPc, instr: rdata});
                mPc = mPc + 32'd4;
            end
        end

        @(posedge clk);
        @(negedge clk);
        checkEq("ValidD", {31'b0, bus.ValidD}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            checkEq("PCD", bus.PCD, q[0].pc);
            checkEq("InstrD", bus.InstrD, q[0].instr);
            checkEq("PCPlus4D", bus.PCPlus4D, q[0].pc + 32'd4);
        end
    endtask

    task automatic doReset();
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] tgt;
        nAsserts = 0;
        nFails   = 0;
        mPc      = RESET_PC;
        mPend    = RESET_PC;
        mDrop    = 0;
        rst            = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.PCSrcE     = 1'b0;
        bus.PCTargetE  = 32'h0;
        bus.StallD     = 1'b0;
        @(negedge clk);
        doReset();

        // Zero-wait streaming, no stall.
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 32'h0, $urandom);

        // Fill under stall, then drain.
        doReset();
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 32'h0, $urandom);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 32'h0, $urandom);

        // Redirect during a slow fetch: DROP, then resume at target.
        doReset();
        step(0, 0, 0, 1, 32'h0000_0100, $urandom);
        step(0, 0, 0, 0, 32'h0, $urandom);
        step(0, 0, 0, 0, 32'h0, $urandom);
        step(0, 1, 0, 0, 32'h0, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 32'h0, $urandom);

        // Redirect coincident with ack while two entries are held.
        doReset();
        step(0, 1, 1, 0, 32'h0, $urandom);
        step(0, 1, 1, 0, 32'h0, $urandom);
        step(0, 1, 1, 1, 32'h0000_0203, $urandom);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0, $urandom);

        // Two redirects inside DROP, the second on the ack cycle.
        doReset();
        step(0, 0, 0, 1, 32'h0000_0300, $urandom);
        step(0, 0, 0, 0, 32'h0, $urandom);
        step(0, 1, 0, 1, 32'h0000_0400, $urandom);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0, $urandom);

        // Reset while in DROP.
        doReset();
        step(0, 0, 0, 1, 32'h0000_0500, $urandom);
        step(1, 0, 0, 0, 32'h0, $urandom);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 32'h0, $urandom);

        // Address wrap at the top of the 32-bit space.
        step(0, 1, 0, 1, 32'hFFFF_FFF4, $urandom);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 32'h0, $urandom);

        // Randomized mix.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                tgt = $urandom;
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 19) == 0,
                 tgt, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
